// File: rtl/alt_mem_ddrx_lpddr2_cmd_decoder.sv
// LPDDR2 AFI command/address decoder: turns the afi_cke/afi_cs_n/afi_addr stream back into commands,
//   tracks per-chip power state and per-bank open state, and flags protocol violations.
// Latency: inputs sampled at posedge N, every output registered and visible in cycle N+1.
// Backpressure: none; one command per clock, dec_valid/err_valid are single-cycle pulses.
//
// Ports:
//   ctl_clk, ctl_reset_n             clock, asynchronous active-low reset
//   afi_cke, afi_cs_n, afi_addr      AFI command bus (upper slice used when CFG_DWIDTH_RATIO=4)
//   dec_valid, dec_cmd, dec_chip     decoded command strobe, opcode, targeted chips
//   dec_bank/row/col/ap/ma/op        decoded fields (zero where the command has no such field)
//   pwr_state                        2 bits per chip: 0 ACTIVE, 1 PD, 2 SREF, 3 DPD
//   bank_open                        8 bits per chip, one per bank
//   err_valid, err_code, err_count   protocol violation pulse, last code, saturating count
module alt_mem_ddrx_lpddr2_cmd_decoder #(
  parameter int CFG_MEM_IF_CHIP       = 1,
  parameter int CFG_MEM_IF_ADDR_WIDTH = 20,
  parameter int CFG_DWIDTH_RATIO      = 2
) (
  input  logic                                                ctl_clk,
  input  logic                                                ctl_reset_n,
  input  logic [CFG_MEM_IF_CHIP*(CFG_DWIDTH_RATIO/2)-1:0]       afi_cke,
  input  logic [CFG_MEM_IF_CHIP*(CFG_DWIDTH_RATIO/2)-1:0]       afi_cs_n,
  input  logic [CFG_MEM_IF_ADDR_WIDTH*(CFG_DWIDTH_RATIO/2)-1:0] afi_addr,
  output logic                                                dec_valid,
  output logic [3:0]                                          dec_cmd,
  output logic [CFG_MEM_IF_CHIP-1:0]                          dec_chip,
  output logic [2:0]                                          dec_bank,
  output logic [14:0]                                         dec_row,
  output logic [11:0]                                         dec_col,
  output logic                                                dec_ap,
  output logic [7:0]                                          dec_ma,
  output logic [7:0]                                          dec_op,
  output logic [2*CFG_MEM_IF_CHIP-1:0]                        pwr_state,
  output logic [8*CFG_MEM_IF_CHIP-1:0]                        bank_open,
  output logic                                                err_valid,
  output logic [2:0]                                          err_code,
  output logic [15:0]                                         err_count
);

  localparam int CH = CFG_MEM_IF_CHIP;
  localparam int PH = CFG_DWIDTH_RATIO / 2;
  localparam int AW = CFG_MEM_IF_ADDR_WIDTH;

  localparam logic [3:0] CMD_ACT   = 4'd0;
  localparam logic [3:0] CMD_WR    = 4'd1;
  localparam logic [3:0] CMD_RD    = 4'd2;
  localparam logic [3:0] CMD_PRE   = 4'd3;
  localparam logic [3:0] CMD_PREA  = 4'd4;
  localparam logic [3:0] CMD_REFAB = 4'd5;
  localparam logic [3:0] CMD_REFPB = 4'd6;
  localparam logic [3:0] CMD_MRW   = 4'd7;
  localparam logic [3:0] CMD_MRR   = 4'd8;
  localparam logic [3:0] CMD_BST   = 4'd9;
  localparam logic [3:0] CMD_SREF  = 4'd10;
  localparam logic [3:0] CMD_PD    = 4'd11;
  localparam logic [3:0] CMD_DPD   = 4'd12;
  localparam logic [3:0] CMD_EXIT  = 4'd13;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL   = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
  localparam logic [2:0] ERR_RW_CLOSED = 3'd3;
  localparam logic [2:0] ERR_BANK_OPEN = 3'd4;
  localparam logic [2:0] ERR_CKE_CODE  = 3'd5;

  // All chips share one CKE, so every chip is always in the same power state.
  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_PD     = 2'd1,
    PWR_SREF   = 2'd2,
    PWR_DPD    = 2'd3
  } pwr_e;

  // ---------------- slice select and field extraction ----------------
  logic [CH-1:0] w_cke_slice;
  logic [CH-1:0] w_cs_n;
  logic          w_cke;
  logic [19:0]   w_a;
  logic [CH-1:0] w_sel;
  logic          w_any_sel;
  logic          w_unused;

  // The last phase of the AFI word is the command slot (upper half at half rate).
  assign w_cke_slice = afi_cke[(PH-1)*CH +: CH];
  assign w_cke       = w_cke_slice[0];
  assign w_cs_n      = afi_cs_n[(PH-1)*CH +: CH];
  assign w_a         = afi_addr[(PH-1)*AW +: 20];
  assign w_sel       = ~w_cs_n;
  assign w_any_sel   = |w_sel;
  assign w_unused    = ^{afi_cke, afi_cs_n, afi_addr};

  logic [2:0]  w_f_bank;
  logic [14:0] w_f_row;
  logic [11:0] w_f_col;
  logic [7:0]  w_f_ma;
  logic [7:0]  w_f_op;
  logic [7:0]  w_bank_mask;

  assign w_f_bank    = w_a[9:7];
  assign w_f_row     = {w_a[19:18], w_a[6:4], w_a[3:2], w_a[17:10]};
  assign w_f_col     = {w_a[19:11], w_a[6:5], 1'b0};
  assign w_f_ma      = {w_a[19:18], w_a[9:4]};
  assign w_f_op      = w_a[17:10];
  assign w_bank_mask = 8'b1 << w_f_bank;

  // ---------------- state registers ----------------
  logic                r_cke_prev;
  pwr_e                r_pwr;
  logic [8*CH-1:0]     r_bank_open;
  logic                r_dec_valid;
  logic [3:0]          r_dec_cmd;
  logic [CH-1:0]       r_dec_chip;
  logic [2:0]          r_dec_bank;
  logic [14:0]         r_dec_row;
  logic [11:0]         r_dec_col;
  logic                r_dec_ap;
  logic [7:0]          r_dec_ma;
  logic [7:0]          r_dec_op;
  logic                r_err_valid;
  logic [2:0]          r_err_code;
  logic [15:0]         r_err_count;

  // ---------------- bank table lookups (OR across selected chips) ----------------
  logic w_sel_hit;       // addressed bank open in some selected chip
  logic w_sel_miss;      // addressed bank closed in some selected chip
  logic w_sel_open_any;  // any bank open in some selected chip
  logic w_all_open_any;  // any bank open anywhere

  always_comb begin
    w_sel_hit      = 1'b0;
    w_sel_miss     = 1'b0;
    w_sel_open_any = 1'b0;
    w_all_open_any = |r_bank_open;
    for (int c = 0; c < CH; c++) begin
      if (w_sel[c]) begin
        if (|(r_bank_open[c*8 +: 8] & w_bank_mask)) w_sel_hit  = 1'b1;
        else                                        w_sel_miss = 1'b1;
        if (|r_bank_open[c*8 +: 8]) w_sel_open_any = 1'b1;
      end
    end
  end

  // ---------------- decode / next-state ----------------
  pwr_e            w_pwr_nxt;
  logic [8*CH-1:0] w_bank_nxt;
  logic            w_vld;
  logic [3:0]      w_cmd;
  logic [CH-1:0]   w_chip;
  logic [2:0]      w_bank;
  logic [14:0]     w_row;
  logic [11:0]     w_col;
  logic            w_ap;
  logic [7:0]      w_ma;
  logic [7:0]      w_op;
  logic [2:0]      w_err_code;

  always_comb begin
    w_pwr_nxt  = r_pwr;
    w_bank_nxt = r_bank_open;
    w_vld      = 1'b0;
    w_cmd      = CMD_ACT;
    w_chip     = w_sel;
    w_bank     = 3'd0;
    w_row      = 15'd0;
    w_col      = 12'd0;
    w_ap       = 1'b0;
    w_ma       = 8'd0;
    w_op       = 8'd0;
    w_err_code = ERR_NONE;

    if (r_cke_prev && w_cke) begin
      if (w_any_sel) begin
        if (w_a[1:0] == 2'b10) begin
          w_vld  = 1'b1;
          w_cmd  = CMD_ACT;
          w_bank = w_f_bank;
          w_row  = w_f_row;
          if (w_sel_hit) w_err_code = ERR_ACT_OPEN;
          for (int c = 0; c < CH; c++)
            if (w_sel[c]) w_bank_nxt[c*8 +: 8] = w_bank_nxt[c*8 +: 8] | w_bank_mask;
        end else begin
          case (w_a[3:0])
            4'b0001, 4'b0101: begin
              w_vld  = 1'b1;
              w_cmd  = w_a[2] ? CMD_RD : CMD_WR;
              w_bank = w_f_bank;
              w_col  = w_f_col;
              w_ap   = w_a[10];
              if (w_sel_miss) w_err_code = ERR_RW_CLOSED;
              // Auto-precharge closes the bank as soon as the command is seen.
              if (w_a[10])
                for (int c = 0; c < CH; c++)
                  if (w_sel[c]) w_bank_nxt[c*8 +: 8] = w_bank_nxt[c*8 +: 8] & ~w_bank_mask;
            end
            4'b1011: begin
              w_vld = 1'b1;
              if (w_a[4]) begin
                w_cmd = CMD_PREA;
                for (int c = 0; c < CH; c++)
                  if (w_sel[c]) w_bank_nxt[c*8 +: 8] = 8'd0;
              end else begin
                w_cmd  = CMD_PRE;
                w_bank = w_f_bank;
                for (int c = 0; c < CH; c++)
                  if (w_sel[c]) w_bank_nxt[c*8 +: 8] = w_bank_nxt[c*8 +: 8] & ~w_bank_mask;
              end
            end
            4'b1100: begin
              w_vld = 1'b1;
              w_cmd = CMD_REFAB;
              if (w_sel_open_any) w_err_code = ERR_BANK_OPEN;
            end
            4'b0100: begin
              w_vld = 1'b1;
              w_cmd = CMD_REFPB;
            end
            4'b0011: begin
              w_vld = 1'b1;
              w_cmd = CMD_BST;
            end
            4'b0000: begin
              w_vld = 1'b1;
              w_cmd = CMD_MRW;
              w_ma  = w_f_ma;
              w_op  = w_f_op;
            end
            4'b1000: begin
              w_vld = 1'b1;
              w_cmd = CMD_MRR;
              w_ma  = w_f_ma;
            end
            4'b1001, 4'b1101: begin
              // Illegal opcodes are reported but never strobed.
              w_err_code = ERR_ILLEGAL;
            end
            default: begin
              // 0111/1111 are NOPs.
            end
          endcase
        end
      end
    end else if (r_cke_prev && !w_cke) begin
      // CKE fall: the whole device enters a low-power state.
      w_vld = 1'b1;
      if (!w_any_sel) begin
        w_cmd     = CMD_PD;
        w_pwr_nxt = PWR_PD;
      end else if (w_a[3:0] == 4'b0100) begin
        w_cmd     = CMD_SREF;
        w_pwr_nxt = PWR_SREF;
        if (w_all_open_any) w_err_code = ERR_BANK_OPEN;
      end else if (w_a[3:0] == 4'b0011) begin
        w_cmd      = CMD_DPD;
        w_pwr_nxt  = PWR_DPD;
        w_bank_nxt = '0;
        if (w_all_open_any) w_err_code = ERR_BANK_OPEN;
      end else begin
        w_cmd      = CMD_PD;
        w_pwr_nxt  = PWR_PD;
        w_err_code = ERR_CKE_CODE;
      end
    end else if (!r_cke_prev && w_cke) begin
      // CKE rise: every chip exits, CS is not looked at this cycle.
      w_vld     = 1'b1;
      w_cmd     = CMD_EXIT;
      w_chip    = '1;
      w_pwr_nxt = PWR_ACTIVE;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      r_cke_prev  <= 1'b1;
      r_pwr       <= PWR_ACTIVE;
      r_bank_open <= '0;
      r_dec_valid <= 1'b0;
      r_dec_cmd   <= 4'd0;
      r_dec_chip  <= '0;
      r_dec_bank  <= 3'd0;
      r_dec_row   <= 15'd0;
      r_dec_col   <= 12'd0;
      r_dec_ap    <= 1'b0;
      r_dec_ma    <= 8'd0;
      r_dec_op    <= 8'd0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_count <= 16'd0;
    end else begin
      r_cke_prev  <= w_cke;
      r_pwr       <= w_pwr_nxt;
      r_bank_open <= w_bank_nxt;
      r_dec_valid <= w_vld;
      if (w_vld) begin
        r_dec_cmd  <= w_cmd;
        r_dec_chip <= w_chip;
        r_dec_bank <= w_bank;
        r_dec_row  <= w_row;
        r_dec_col  <= w_col;
        r_dec_ap   <= w_ap;
        r_dec_ma   <= w_ma;
        r_dec_op   <= w_op;
      end
      r_err_valid <= (w_err_code != ERR_NONE);
      if (w_err_code != ERR_NONE) begin
        r_err_code <= w_err_code;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  logic [1:0] w_pwr_bits;
  assign w_pwr_bits = r_pwr;

  assign dec_valid = r_dec_valid;
  assign dec_cmd   = r_dec_cmd;
  assign dec_chip  = r_dec_chip;
  assign dec_bank  = r_dec_bank;
  assign dec_row   = r_dec_row;
  assign dec_col   = r_dec_col;
  assign dec_ap    = r_dec_ap;
  assign dec_ma    = r_dec_ma;
  assign dec_op    = r_dec_op;
  assign pwr_state = {CH{w_pwr_bits}};
  assign bank_open = r_bank_open;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alt_mem_ddrx_lpddr2_cmd_decoder.sv
// Directed bench for alt_mem_ddrx_lpddr2_cmd_decoder: a full-rate instance (A) walks through the
//   command set, bank tracking, power states and error codes; a half-rate instance (B) checks that
//   only the upper slice is decoded. Expected values are hand-computed constants.
module tb_alt_mem_ddrx_lpddr2_cmd_decoder;

  logic ctl_clk = 1'b0;
  logic ctl_reset_n = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  // Instance A: full rate
  logic        a_cke;
  logic        a_cs_n;
  logic [19:0] a_addr;
  logic        a_dec_valid;
  logic [3:0]  a_dec_cmd;
  logic [0:0]  a_dec_chip;
  logic [2:0]  a_dec_bank;
  logic [14:0] a_dec_row;
  logic [11:0] a_dec_col;
  logic        a_dec_ap;
  logic [7:0]  a_dec_ma;
  logic [7:0]  a_dec_op;
  logic [1:0]  a_pwr_state;
  logic [7:0]  a_bank_open;
  logic        a_err_valid;
  logic [2:0]  a_err_code;
  logic [15:0] a_err_count;

  // Instance B: half rate
  logic [1:0]  b_cke;
  logic [1:0]  b_cs_n;
  logic [39:0] b_addr;
  logic        b_dec_valid;
  logic [3:0]  b_dec_cmd;
  logic [0:0]  b_dec_chip;
  logic [2:0]  b_dec_bank;
  logic [14:0] b_dec_row;
  logic [11:0] b_dec_col;
  logic        b_dec_ap;
  logic [7:0]  b_dec_ma;
  logic [7:0]  b_dec_op;
  logic [1:0]  b_pwr_state;
  logic [7:0]  b_bank_open;
  logic        b_err_valid;
  logic [2:0]  b_err_code;
  logic [15:0] b_err_count;

  alt_mem_ddrx_lpddr2_cmd_decoder #(
    .CFG_MEM_IF_CHIP(1), .CFG_MEM_IF_ADDR_WIDTH(20), .CFG_DWIDTH_RATIO(2)
  ) dut_a (
    .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n),
    .afi_cke(a_cke), .afi_cs_n(a_cs_n), .afi_addr(a_addr),
    .dec_valid(a_dec_valid), .dec_cmd(a_dec_cmd), .dec_chip(a_dec_chip),
    .dec_bank(a_dec_bank), .dec_row(a_dec_row), .dec_col(a_dec_col), .dec_ap(a_dec_ap),
    .dec_ma(a_dec_ma), .dec_op(a_dec_op), .pwr_state(a_pwr_state), .bank_open(a_bank_open),
    .err_valid(a_err_valid), .err_code(a_err_code), .err_count(a_err_count)
  );

  alt_mem_ddrx_lpddr2_cmd_decoder #(
    .CFG_MEM_IF_CHIP(1), .CFG_MEM_IF_ADDR_WIDTH(20), .CFG_DWIDTH_RATIO(4)
  ) dut_b (
    .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n),
    .afi_cke(b_cke), .afi_cs_n(b_cs_n), .afi_addr(b_addr),
    .dec_valid(b_dec_valid), .dec_cmd(b_dec_cmd), .dec_chip(b_dec_chip),
    .dec_bank(b_dec_bank), .dec_row(b_dec_row), .dec_col(b_dec_col), .dec_ap(b_dec_ap),
    .dec_ma(b_dec_ma), .dec_op(b_dec_op), .pwr_state(b_pwr_state), .bank_open(b_bank_open),
    .err_valid(b_err_valid), .err_code(b_err_code), .err_count(b_err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one command into A (B idle), sampled at the next posedge, outputs read 1ns later.
  task automatic step_a(input logic cke, input logic cs_n, input logic [19:0] addr);
    @(negedge ctl_clk);
    a_cke = cke; a_cs_n = cs_n; a_addr = addr;
    b_cke = 2'b11; b_cs_n = 2'b11; b_addr = '0;
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic step_b(input logic [1:0] cke, input logic [1:0] cs_n, input logic [39:0] addr);
    @(negedge ctl_clk);
    a_cke = 1'b1; a_cs_n = 1'b1; a_addr = '0;
    b_cke = cke; b_cs_n = cs_n; b_addr = addr;
    @(posedge ctl_clk);
    #1;
  endtask

  initial begin
    a_cke = 1'b1; a_cs_n = 1'b1; a_addr = '0;
    b_cke = 2'b11; b_cs_n = 2'b11; b_addr = '0;
    repeat (3) @(posedge ctl_clk);
    #1;
    check("rst_valid",  a_dec_valid, 0);
    check("rst_cmd",    a_dec_cmd,   0);
    check("rst_errv",   a_err_valid, 0);
    check("rst_pwr",    a_pwr_state, 0);
    check("rst_bank",   a_bank_open, 0);
    check("rst_errcnt", a_err_count, 0);
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;

    // ACT 0x2A5E2: bank=a[9:7]=3, row={00,110,00,0xA9}=0x18A9
    step_a(1'b1, 1'b0, 20'h2A5E2);
    check("act1_valid", a_dec_valid, 1);
    check("act1_cmd",   a_dec_cmd,   0);
    check("act1_chip",  a_dec_chip,  1);
    check("act1_bank",  a_dec_bank,  3);
    check("act1_row",   a_dec_row,   15'h18A9);
    check("act1_open",  a_bank_open, 8'h08);
    check("act1_errv",  a_err_valid, 0);

    // ACT bank 7
    step_a(1'b1, 1'b0, 20'h00382);
    check("act7_bank", a_dec_bank,  7);
    check("act7_row",  a_dec_row,   0);
    check("act7_open", a_bank_open, 8'h88);

    // RD bank 3, ap=1, col={9'h155,2'b11,0}=0xAAE
    step_a(1'b1, 1'b0, 20'hAADE5);
    check("rdap_cmd",  a_dec_cmd,   2);
    check("rdap_bank", a_dec_bank,  3);
    check("rdap_col",  a_dec_col,   12'hAAE);
    check("rdap_ap",   a_dec_ap,    1);
    check("rdap_open", a_bank_open, 8'h80);
    check("rdap_errv", a_err_valid, 0);

    // RD bank 3 again: closed bank
    step_a(1'b1, 1'b0, 20'hAADE5);
    check("rd2_valid", a_dec_valid, 1);
    check("rd2_errv",  a_err_valid, 1);
    check("rd2_code",  a_err_code,  3);
    check("rd2_cnt",   a_err_count, 1);

    step_a(1'b1, 1'b0, 20'h00002);
    check("act0_open", a_bank_open, 8'h81);
    check("act0_errv", a_err_valid, 0);
    step_a(1'b1, 1'b0, 20'h00002);
    check("act0b_valid", a_dec_valid, 1);
    check("act0b_code",  a_err_code,  2);
    check("act0b_cnt",   a_err_count, 2);
    check("act0b_open",  a_bank_open, 8'h81);

    step_a(1'b1, 1'b0, 20'h0001B);
    check("prea_cmd",  a_dec_cmd,   4);
    check("prea_open", a_bank_open, 0);

    // WR to closed bank 2, ap=0
    step_a(1'b1, 1'b0, 20'h00101);
    check("wr_cmd",  a_dec_cmd,  1);
    check("wr_bank", a_dec_bank, 2);
    check("wr_ap",   a_dec_ap,   0);
    check("wr_code", a_err_code, 3);
    check("wr_cnt",  a_err_count, 3);

    step_a(1'b1, 1'b0, 20'h00282);
    check("act5_open", a_bank_open, 8'h20);
    step_a(1'b1, 1'b0, 20'h0000C);
    check("refab_cmd",  a_dec_cmd,   5);
    check("refab_code", a_err_code,  4);
    check("refab_cnt",  a_err_count, 4);
    check("refab_open", a_bank_open, 8'h20);
    step_a(1'b1, 1'b0, 20'h0028B);
    check("pre_cmd",  a_dec_cmd,   3);
    check("pre_bank", a_dec_bank,  5);
    check("pre_open", a_bank_open, 0);

    // Self refresh entry, hold, exit
    step_a(1'b0, 1'b0, 20'h00004);
    check("sref_cmd",  a_dec_cmd,   10);
    check("sref_pwr",  a_pwr_state, 2);
    check("sref_errv", a_err_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 1'b0, 20'h00002);
      check("hold_valid", a_dec_valid, 0);
      check("hold_errv",  a_err_valid, 0);
      check("hold_pwr",   a_pwr_state, 2);
    end
    step_a(1'b1, 1'b0, 20'h00002);
    check("exit_valid", a_dec_valid, 1);
    check("exit_cmd",   a_dec_cmd,   13);
    check("exit_pwr",   a_pwr_state, 0);
    check("exit_open",  a_bank_open, 0);

    // Power-down with CS high
    step_a(1'b0, 1'b1, 20'h00000);
    check("pd_cmd",  a_dec_cmd,   11);
    check("pd_pwr",  a_pwr_state, 1);
    check("pd_errv", a_err_valid, 0);
    step_a(1'b1, 1'b1, 20'h00000);
    check("pdx_cmd", a_dec_cmd,   13);

    // Bad CKE-fall code
    step_a(1'b0, 1'b0, 20'h00001);
    check("badf_cmd",  a_dec_cmd,   11);
    check("badf_pwr",  a_pwr_state, 1);
    check("badf_code", a_err_code,  5);
    check("badf_cnt",  a_err_count, 5);
    step_a(1'b1, 1'b1, 20'h00000);
    check("badfx_pwr", a_pwr_state, 0);

    // DPD with bank 1 open
    step_a(1'b1, 1'b0, 20'h00082);
    check("act1b_open", a_bank_open, 8'h02);
    step_a(1'b0, 1'b0, 20'h00003);
    check("dpd_cmd",  a_dec_cmd,   12);
    check("dpd_pwr",  a_pwr_state, 3);
    check("dpd_code", a_err_code,  4);
    check("dpd_cnt",  a_err_count, 6);
    check("dpd_open", a_bank_open, 0);
    step_a(1'b1, 1'b1, 20'h00000);
    check("dpdx_pwr", a_pwr_state, 0);

    // MRW {10, A5, 3F, 0000} and MRR
    step_a(1'b1, 1'b0, 20'hA97F0);
    check("mrw_cmd", a_dec_cmd, 7);
    check("mrw_ma",  a_dec_ma,  8'hBF);
    check("mrw_op",  a_dec_op,  8'hA5);
    step_a(1'b1, 1'b0, 20'hA97F8);
    check("mrr_cmd", a_dec_cmd, 8);
    check("mrr_ma",  a_dec_ma,  8'hBF);
    check("mrr_op",  a_dec_op,  0);
    step_a(1'b1, 1'b0, 20'h00003);
    check("bst_cmd", a_dec_cmd, 9);
    step_a(1'b1, 1'b0, 20'h00004);
    check("refpb_cmd",  a_dec_cmd,   6);
    check("refpb_errv", a_err_valid, 0);

    // Illegal opcodes: error without strobe
    step_a(1'b1, 1'b0, 20'h0000D);
    check("ill_d_valid", a_dec_valid, 0);
    check("ill_d_errv",  a_err_valid, 1);
    check("ill_d_code",  a_err_code,  1);
    check("ill_d_cnt",   a_err_count, 7);
    step_a(1'b1, 1'b0, 20'h00009);
    check("ill_9_valid", a_dec_valid, 0);
    check("ill_9_cnt",   a_err_count, 8);
    step_a(1'b1, 1'b0, 20'h00007);
    check("nop_valid", a_dec_valid, 0);
    check("nop_errv",  a_err_valid, 0);
    check("nop_cnt",   a_err_count, 8);

    // Reset mid-operation with a bank open and power-down active
    step_a(1'b1, 1'b0, 20'h00202);
    check("act4_open", a_bank_open, 8'h10);
    step_a(1'b0, 1'b1, 20'h00000);
    check("pd2_pwr",  a_pwr_state, 1);
    check("pd2_open", a_bank_open, 8'h10);
    @(negedge ctl_clk);
    ctl_reset_n = 1'b0;
    #1;
    check("mrst_open",  a_bank_open, 0);
    check("mrst_pwr",   a_pwr_state, 0);
    check("mrst_cnt",   a_err_count, 0);
    check("mrst_valid", a_dec_valid, 0);
    a_cke = 1'b1; a_cs_n = 1'b1; a_addr = '0;
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;

    // Half rate: command in upper slice, lower slice carries CKE low and an illegal code
    step_b(2'b10, 2'b00, {20'hA97F0, 20'h0000D});
    check("b_mrw_valid", b_dec_valid, 1);
    check("b_mrw_cmd",   b_dec_cmd,   7);
    check("b_mrw_ma",    b_dec_ma,    8'hBF);
    check("b_mrw_op",    b_dec_op,    8'hA5);
    check("b_mrw_errv",  b_err_valid, 0);
    check("b_mrw_pwr",   b_pwr_state, 0);
    step_b(2'b10, 2'b01, {20'h2A5E2, 20'h00382});
    check("b_act_cmd",  b_dec_cmd,   0);
    check("b_act_bank", b_dec_bank,  3);
    check("b_act_row",  b_dec_row,   15'h18A9);
    check("b_act_open", b_bank_open, 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
